// File: rtl/node_pkt_sender_pkg.sv
// ---------------------------------------------------------------------------
// node_pkt_sender_pkg
// Shared NoC types for the node-side transmit stage.
//   pkt_t          : 32-bit packet {source_id, dest_id, data}
//   BEATS_PER_PKT  : beats per serialized packet (4)
//   BEAT_W         : beat width in bits (8)
//   sender_state_t : serializer FSM states
//   pkt_beat()     : selects beat idx of a packet, beat 0 = MSB byte
// ---------------------------------------------------------------------------
package node_pkt_sender_pkg;

    typedef struct packed {
        logic [3:0]  source_id;
        logic [3:0]  dest_id;
        logic [23:0] data;
    } pkt_t;

    localparam int BEATS_PER_PKT = 4;
    localparam int BEAT_W        = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sender_state_t;

    function automatic logic [BEAT_W-1:0] pkt_beat(input pkt_t p, input logic [1:0] idx);
        logic [31:0] w;
        logic [BEAT_W-1:0] b;
        w = p;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/node_pkt_sender_fifo.sv
// ---------------------------------------------------------------------------
// node_pkt_sender_fifo
// Circular queue of QDEPTH pkt_t entries (QDEPTH power of 2, >= 2).
// Ports:
//   clk, rst_b        : clock, asynchronous active-low reset
//   push, push_data   : enqueue request/data (ignored while full)
//   pop               : dequeue request (ignored while empty)
//   head              : entry at the read pointer
//   count, full, empty: registered occupancy status
// Handshake: an entry moves in when push & !full at a posedge, and out when
// pop & !empty at a posedge. Both in one cycle leave count unchanged.
// ---------------------------------------------------------------------------
module node_pkt_sender_fifo
    import node_pkt_sender_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      push,
    input  pkt_t                      push_data,
    input  logic                      pop,
    output pkt_t                      head,
    output logic [$clog2(QDEPTH):0]   count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(QDEPTH);

    pkt_t          mem_q [QDEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(QDEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers are exactly AW bits, so the natural overflow wraps modulo QDEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/node_pkt_sender.sv
// ---------------------------------------------------------------------------
// node_pkt_sender
// Node-side transmit stage: queues whole packets and serializes each into
// four 8-bit beats (MSB byte first) toward a router inbound port.
// Ports:
//   clk, rst_b            : clock, asynchronous active-low reset
//   pkt_in, pkt_in_valid  : packet from node
//   pkt_in_ready          : queue has room
//   free                  : router inbound has room for a new packet
//   put, payload          : beat valid strobe and beat data
//   busy                  : queue non-empty or a packet in flight
//   sent_count            : completed packets (only with NODE_PKT_SENDER_STATS_EN)
//   dbg_state_o           : serializer FSM state, for observation
// Handshake: node -> queue uses valid/ready; a packet transfers when
// pkt_in_valid & pkt_in_ready at a posedge. The router side has no ready:
// free is sampled only before a packet starts, after which all four beats
// are issued on consecutive cycles with put high.
// Optional feature macro: NODE_PKT_SENDER_STATS_EN.
// ---------------------------------------------------------------------------
module node_pkt_sender
    import node_pkt_sender_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  pkt_t              pkt_in,
    input  logic              pkt_in_valid,
    output logic              pkt_in_ready,
    input  logic              free,
    output logic              put,
    output logic [BEAT_W-1:0] payload,
    output logic              busy,
`ifdef NODE_PKT_SENDER_STATS_EN
    output logic [15:0]       sent_count,
`endif
    output sender_state_t     dbg_state_o
);

    sender_state_t       state_q,   state_d;
    logic [2:0]          beat_q,    beat_d;
    pkt_t                shift_q,   shift_d;
    logic                put_q,     put_d;
    logic [BEAT_W-1:0]   payload_q, payload_d;

    pkt_t                fifo_head;
    logic [$clog2(QDEPTH):0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                pkt_done;

    node_pkt_sender_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (pkt_in_valid),
        .push_data (pkt_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ready comes from the registered count only; no same-cycle bypass.
    assign pkt_in_ready = ~fifo_full;
    assign put          = put_q;
    assign payload      = payload_q;
    assign busy         = ~fifo_empty | (state_q != IDLE);
    assign dbg_state_o  = state_q;

    // beat_q holds the index of the next beat to drive; reaching
    // BEATS_PER_PKT means the last beat has been on the link for one cycle.
    assign pkt_done = (state_q == SEND) && (beat_q == 3'(BEATS_PER_PKT));

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        shift_d   = shift_q;
        put_d     = put_q;
        payload_d = payload_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                put_d     = 1'b0;
                payload_d = '0;
                if (!fifo_empty && free) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_head;
                    put_d     = 1'b1;
                    payload_d = pkt_beat(fifo_head, 2'd0);
                    beat_d    = 3'd1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                // free is deliberately ignored here: the router slot is committed.
                if (pkt_done) begin
                    put_d     = 1'b0;
                    payload_d = '0;
                    beat_d    = 3'd0;
                    state_d   = IDLE;
                end else begin
                    put_d     = 1'b1;
                    payload_d = pkt_beat(shift_q, beat_q[1:0]);
                    beat_d    = beat_q + 3'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                put_d     = 1'b0;
                payload_d = '0;
                beat_d    = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            beat_q    <= 3'd0;
            shift_q   <= '0;
            put_q     <= 1'b0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            shift_q   <= shift_d;
            put_q     <= put_d;
            payload_q <= payload_d;
        end
    end

`ifdef NODE_PKT_SENDER_STATS_EN
    logic [15:0] sent_count_q, sent_count_d;

    // Wraps naturally from 16'hFFFF to 0.
    assign sent_count_d = pkt_done ? (sent_count_q + 16'd1) : sent_count_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) sent_count_q <= '0;
        else        sent_count_q <= sent_count_d;
    end

    assign sent_count = sent_count_q;
`endif

endmodule

// File: tb/tb_node_pkt_sender.sv
module tb_node_pkt_sender;
    import node_pkt_sender_pkg::*;

    logic          clk;
    logic          rst_b;
    logic [31:0]   pkt_in;
    logic          pkt_in_valid;
    logic          pkt_in_ready;
    logic          free;
    logic          put;
    logic [7:0]    payload;
    logic          busy;
    sender_state_t dbg_state;
`ifdef NODE_PKT_SENDER_STATS_EN
    logic [15:0]   sent_count;
`endif

    node_pkt_sender #(.QDEPTH(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .pkt_in       (pkt_in),
        .pkt_in_valid (pkt_in_valid),
        .pkt_in_ready (pkt_in_ready),
        .free         (free),
        .put          (put),
        .payload      (payload),
        .busy         (busy),
`ifdef NODE_PKT_SENDER_STATS_EN
        .sent_count   (sent_count),
`endif
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int n_cmp;
    int n_err;
    int mon_beats;
    int exp_sent;

    typedef struct {
        logic [31:0] pkt;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_pkt(input logic [31:0] p, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        int k;
        k = 0;
        while (!pkt_in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!pkt_in_ready) begin
            check("push_ready_timeout", {31'd0, pkt_in_ready}, 32'd1);
        end else begin
            pkt_in       = p;
            pkt_in_valid = 1'b1;
            exp_q.push_back(b0);
            exp_q.push_back(b1);
            exp_q.push_back(b2);
            exp_q.push_back(b3);
            @(posedge clk); #1;
            pkt_in_valid = 1'b0;
        end
    endtask

    task automatic push_plain(input logic [31:0] p);
        push_pkt(p, p[31:24], p[23:16], p[15:8], p[7:0]);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        // one extra negedge so the monitor sees the final put-low cycle
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_exp_empty", exp_q.size(), 32'd0);
    endtask

    task automatic wait_put();
        int k;
        k = 0;
        @(negedge clk);
        while (!put && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("wait_put_timeout", {31'd0, put}, 32'd1);
    endtask

    // ---------------- main test ----------------
    initial begin
        logic [11:0] pat;
        logic [10:0] pat2;
        int beats0;

        n_cmp = 0; n_err = 0; mon_beats = 0; exp_sent = 0;
        rst_b = 1'b0; pkt_in = '0; pkt_in_valid = 1'b0; free = 1'b0;

        vecs[0] = '{32'h15ABCDEF, 8'h15, 8'hAB, 8'hCD, 8'hEF};
        vecs[1] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[3] = '{32'hA5123456, 8'hA5, 8'h12, 8'h34, 8'h56};
        vecs[4] = '{32'h7E80017F, 8'h7E, 8'h80, 8'h01, 8'h7F};

        // scoreboard monitor: every put-high beat is popped and compared,
        // every put run must be exactly four cycles long
        fork
            begin
                int run;
                logic [7:0] e;
                run = 0;
                forever begin
                    @(negedge clk);
                    if (!rst_b) begin
                        run = 0;
                    end else if (put) begin
                        run++;
                        mon_beats++;
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL beat_unexpected: payload %0h with none queued, required no beat (t=%0t)", payload, $time);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat_payload", {24'd0, payload}, {24'd0, e});
                        end
                    end else begin
                        check("idle_payload_zero", {24'd0, payload}, 32'd0);
                        if (run != 0) begin
                            check("put_run_len", run, 32'd4);
                            exp_sent++;
                            run = 0;
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("rst_put", {31'd0, put}, 32'd0);
        check("rst_payload", {24'd0, payload}, 32'd0);
        check("rst_ready", {31'd0, pkt_in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
`ifdef NODE_PKT_SENDER_STATS_EN
        check("rst_sent_count", {16'd0, sent_count}, 32'd0);
`endif
        rst_b = 1'b1;
        @(posedge clk); #1;

        // single packet with latency check
        free = 1'b1;
        push_plain(32'h15ABCDEF);
        @(negedge clk);
        check("lat_put_low_after_push", {31'd0, put}, 32'd0);
        check("lat_busy_after_push", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("lat_put_first_beat", {31'd0, put}, 32'd1);
        repeat (3) @(negedge clk);
        check("single_last_beat_put", {31'd0, put}, 32'd1);
        check("single_last_beat_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("single_put_fall", {31'd0, put}, 32'd0);
        check("single_busy_fall", {31'd0, busy}, 32'd0);
        wait_idle();

        // table-driven vectors, queued back to back
        for (int i = 0; i < 5; i++) begin
            push_pkt(vecs[i].pkt, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
        end
        wait_idle();

        // backpressure: two packets held while free is low
        @(posedge clk); #1;
        free = 1'b0;
        push_plain(32'h12345678);
        push_plain(32'h9ABCDEF0);
        beats0 = mon_beats;
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_beats", mon_beats - beats0, 32'd0);
        check("bp_busy", {31'd0, busy}, 32'd1);
        free = 1'b1;
        for (int i = 11; i >= 0; i--) begin
            @(negedge clk);
            pat[i] = put;
        end
        check("bp_put_pattern", {20'd0, pat}, {20'd0, 12'b0111_1011_1100});
        wait_idle();

        // full queue: fifth packet refused, four drain in order
        @(posedge clk); #1;
        free = 1'b0;
        push_plain(32'h01000001);
        push_plain(32'h02000002);
        push_plain(32'h03000003);
        check("full_ready_before_4th", {31'd0, pkt_in_ready}, 32'd1);
        push_plain(32'h04000004);
        check("full_ready_after_4th", {31'd0, pkt_in_ready}, 32'd0);
        pkt_in = 32'h05000005;
        pkt_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("full_ready_held_low", {31'd0, pkt_in_ready}, 32'd0);
        end
        pkt_in_valid = 1'b0;
        beats0 = mon_beats;
        free = 1'b1;
        wait_idle();
        check("full_beats_total", mon_beats - beats0, 32'd16);

        // free drops during beat 1: packet completes, next one waits
        @(posedge clk); #1;
        free = 1'b0;
        push_plain(32'hC1D2E3F4);
        push_plain(32'h2B3C4D5E);
        @(posedge clk); #1;
        free = 1'b1;
        wait_put();
        @(posedge clk); #1;
        free = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            pat2[i] = put;
        end
        check("drop_put_pattern", {21'd0, pat2}, {21'd0, 11'b111_0000_0000});
        check("drop_still_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        free = 1'b1;
        wait_idle();

        // streaming ten packets: exercises pointer wrap and push/pop overlap
        for (int i = 0; i < 10; i++) begin
            push_plain({8'h37, 24'(i)});
        end
        wait_idle();
`ifdef NODE_PKT_SENDER_STATS_EN
        check("stats_sent_count", {16'd0, sent_count}, exp_sent);
`endif

        // reset mid-packet during beat 2
        @(posedge clk); #1;
        push_plain(32'hDEADBEEF);
        wait_put();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_beat2_put", {31'd0, put}, 32'd1);
        rst_b = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_put", {31'd0, put}, 32'd0);
        check("mid_rst_payload", {24'd0, payload}, 32'd0);
        exp_sent = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        #1;
        check("mid_rel_busy", {31'd0, busy}, 32'd0);
        check("mid_rel_ready", {31'd0, pkt_in_ready}, 32'd1);
`ifdef NODE_PKT_SENDER_STATS_EN
        check("mid_rel_sent_count", {16'd0, sent_count}, 32'd0);
`endif
        @(posedge clk); #1;
        push_plain(32'h6A7B8C9D);
        wait_idle();
`ifdef NODE_PKT_SENDER_STATS_EN
        check("post_rst_sent_count", {16'd0, sent_count}, exp_sent);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
